// File: rtl/ps2_key_pkg.sv
// ps2_key_pkg: shared scan-code constants, FSM states, LUT entry and sequence helpers
package ps2_key_pkg;
  localparam logic [7:0] SC_BREAK = 8'hF0, SC_EXT = 8'hE0, SC_LSHIFT = 8'h12;
  localparam logic [7:0] HK_ENTER = 8'd128, HK_BKSP = 8'd129, HK_LEFT = 8'd130, HK_UP = 8'd131;
  localparam logic [7:0] HK_RIGHT = 8'd132, HK_DOWN = 8'd133, HK_HOME = 8'd134, HK_END = 8'd135;
  localparam logic [7:0] HK_PGUP = 8'd136, HK_PGDN = 8'd137, HK_INS = 8'd138, HK_DEL = 8'd139;
  localparam logic [7:0] HK_ESC = 8'd140, HK_F1 = 8'd141, HK_F2 = 8'd142, HK_F3 = 8'd143;
  localparam logic [7:0] HK_F4 = 8'd144, HK_F5 = 8'd145, HK_F6 = 8'd146, HK_F7 = 8'd147;
  localparam logic [7:0] HK_F8 = 8'd148, HK_F9 = 8'd149, HK_F10 = 8'd150, HK_F11 = 8'd151;
  localparam logic [7:0] HK_F12 = 8'd152;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  typedef struct packed {
    logic [7:0] code;
    logic       shift;
    logic       ext;
    logic       valid;
  } lut_entry_t;
  function automatic lut_entry_t mk(input logic [7:0] c, input logic s, input logic x);
    return '{code: c, shift: s, ext: x, valid: 1'b1};
  endfunction
  function automatic logic [2:0] seq_len(input lut_entry_t e);
    return e.ext ? 3'd5 : e.shift ? 3'd6 : 3'd3;
  endfunction
  // plain: C F0 C / shift: 12 C F0 C F0 12 / ext: E0 C E0 F0 C
  function automatic logic [7:0] seq_byte(input lut_entry_t e, input logic [2:0] i);
    return e.ext   ? ((i == 3'd1 || i == 3'd4) ? e.code : (i == 3'd3) ? SC_BREAK : SC_EXT) :
           e.shift ? ((i == 3'd0 || i == 3'd5) ? SC_LSHIFT : (i == 3'd1 || i == 3'd3) ? e.code : SC_BREAK) :
                     ((i == 3'd1) ? SC_BREAK : e.code);
  endfunction
endpackage

// File: rtl/ps2_key_encoder_if.sv
// ps2_key_encoder_if: character-in / scan-byte-out handshake bundle
interface ps2_key_encoder_if;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       scan_ready;
  logic       busy;
  logic       unmapped;
  modport slave (input char_in, char_valid, scan_ready, output char_ready, scan_code, scan_valid, busy, unmapped);
  modport master (output char_in, char_valid, scan_ready, input char_ready, scan_code, scan_valid, busy, unmapped);
endinterface

// File: rtl/ps2_key_lut.sv
// ps2_key_lut: combinational character code to Set-2 make code lookup
module ps2_key_lut
  import ps2_key_pkg::*;
(
  input  logic [7:0] i_char,
  output lut_entry_t o_entry
);
  logic       w_up;
  logic [7:0] w_ch;
  // uppercase folds onto its lowercase key with shift set
  assign w_up = i_char inside {[8'd65:8'd90]};
  assign w_ch = w_up ? i_char + 8'd32 : i_char;
  always_comb begin
    o_entry = '0;
    case (w_ch)
      "a": o_entry = mk(8'h1C, w_up, 1'b0);  "b": o_entry = mk(8'h32, w_up, 1'b0);
      "c": o_entry = mk(8'h21, w_up, 1'b0);  "d": o_entry = mk(8'h23, w_up, 1'b0);
      "e": o_entry = mk(8'h24, w_up, 1'b0);  "f": o_entry = mk(8'h2B, w_up, 1'b0);
      "g": o_entry = mk(8'h34, w_up, 1'b0);  "h": o_entry = mk(8'h33, w_up, 1'b0);
      "i": o_entry = mk(8'h43, w_up, 1'b0);  "j": o_entry = mk(8'h3B, w_up, 1'b0);
      "k": o_entry = mk(8'h42, w_up, 1'b0);  "l": o_entry = mk(8'h4B, w_up, 1'b0);
      "m": o_entry = mk(8'h3A, w_up, 1'b0);  "n": o_entry = mk(8'h31, w_up, 1'b0);
      "o": o_entry = mk(8'h44, w_up, 1'b0);  "p": o_entry = mk(8'h4D, w_up, 1'b0);
      "q": o_entry = mk(8'h15, w_up, 1'b0);  "r": o_entry = mk(8'h2D, w_up, 1'b0);
      "s": o_entry = mk(8'h1B, w_up, 1'b0);  "t": o_entry = mk(8'h2C, w_up, 1'b0);
      "u": o_entry = mk(8'h3C, w_up, 1'b0);  "v": o_entry = mk(8'h2A, w_up, 1'b0);
      "w": o_entry = mk(8'h1D, w_up, 1'b0);  "x": o_entry = mk(8'h22, w_up, 1'b0);
      "y": o_entry = mk(8'h35, w_up, 1'b0);  "z": o_entry = mk(8'h1A, w_up, 1'b0);
      "0": o_entry = mk(8'h45, 1'b0, 1'b0);  ")": o_entry = mk(8'h45, 1'b1, 1'b0);
      "1": o_entry = mk(8'h16, 1'b0, 1'b0);  "!": o_entry = mk(8'h16, 1'b1, 1'b0);
      "2": o_entry = mk(8'h1E, 1'b0, 1'b0);  "@": o_entry = mk(8'h1E, 1'b1, 1'b0);
      "3": o_entry = mk(8'h26, 1'b0, 1'b0);  "#": o_entry = mk(8'h26, 1'b1, 1'b0);
      "4": o_entry = mk(8'h25, 1'b0, 1'b0);  "$": o_entry = mk(8'h25, 1'b1, 1'b0);
      "5": o_entry = mk(8'h2E, 1'b0, 1'b0);  "%": o_entry = mk(8'h2E, 1'b1, 1'b0);
      "6": o_entry = mk(8'h36, 1'b0, 1'b0);  "^": o_entry = mk(8'h36, 1'b1, 1'b0);
      "7": o_entry = mk(8'h3D, 1'b0, 1'b0);  "&": o_entry = mk(8'h3D, 1'b1, 1'b0);
      "8": o_entry = mk(8'h3E, 1'b0, 1'b0);  "*": o_entry = mk(8'h3E, 1'b1, 1'b0);
      "9": o_entry = mk(8'h46, 1'b0, 1'b0);  "(": o_entry = mk(8'h46, 1'b1, 1'b0);
      8'h60: o_entry = mk(8'h0E, 1'b0, 1'b0); 8'h7E: o_entry = mk(8'h0E, 1'b1, 1'b0);
      "-": o_entry = mk(8'h4E, 1'b0, 1'b0);  "_": o_entry = mk(8'h4E, 1'b1, 1'b0);
      "=": o_entry = mk(8'h55, 1'b0, 1'b0);  "+": o_entry = mk(8'h55, 1'b1, 1'b0);
      "[": o_entry = mk(8'h54, 1'b0, 1'b0);  "{": o_entry = mk(8'h54, 1'b1, 1'b0);
      "]": o_entry = mk(8'h5B, 1'b0, 1'b0);  "}": o_entry = mk(8'h5B, 1'b1, 1'b0);
      8'h5C: o_entry = mk(8'h5D, 1'b0, 1'b0); "|": o_entry = mk(8'h5D, 1'b1, 1'b0);
      ";": o_entry = mk(8'h4C, 1'b0, 1'b0);  ":": o_entry = mk(8'h4C, 1'b1, 1'b0);
      8'h27: o_entry = mk(8'h52, 1'b0, 1'b0); 8'h22: o_entry = mk(8'h52, 1'b1, 1'b0);
      ",": o_entry = mk(8'h41, 1'b0, 1'b0);  "<": o_entry = mk(8'h41, 1'b1, 1'b0);
      ".": o_entry = mk(8'h49, 1'b0, 1'b0);  ">": o_entry = mk(8'h49, 1'b1, 1'b0);
      "/": o_entry = mk(8'h4A, 1'b0, 1'b0);  "?": o_entry = mk(8'h4A, 1'b1, 1'b0);
      " ": o_entry = mk(8'h29, 1'b0, 1'b0);  8'd9: o_entry = mk(8'h0D, 1'b0, 1'b0);
      HK_ENTER: o_entry = mk(8'h5A, 1'b0, 1'b0); HK_BKSP: o_entry = mk(8'h66, 1'b0, 1'b0);
      HK_ESC:   o_entry = mk(8'h76, 1'b0, 1'b0);
      HK_LEFT:  o_entry = mk(8'h6B, 1'b0, 1'b1); HK_UP:    o_entry = mk(8'h75, 1'b0, 1'b1);
      HK_RIGHT: o_entry = mk(8'h74, 1'b0, 1'b1); HK_DOWN:  o_entry = mk(8'h72, 1'b0, 1'b1);
      HK_HOME:  o_entry = mk(8'h6C, 1'b0, 1'b1); HK_END:   o_entry = mk(8'h69, 1'b0, 1'b1);
      HK_PGUP:  o_entry = mk(8'h7D, 1'b0, 1'b1); HK_PGDN:  o_entry = mk(8'h7A, 1'b0, 1'b1);
      HK_INS:   o_entry = mk(8'h70, 1'b0, 1'b1); HK_DEL:   o_entry = mk(8'h71, 1'b0, 1'b1);
      HK_F1:  o_entry = mk(8'h05, 1'b0, 1'b0); HK_F2:  o_entry = mk(8'h06, 1'b0, 1'b0);
      HK_F3:  o_entry = mk(8'h04, 1'b0, 1'b0); HK_F4:  o_entry = mk(8'h0C, 1'b0, 1'b0);
      HK_F5:  o_entry = mk(8'h03, 1'b0, 1'b0); HK_F6:  o_entry = mk(8'h0B, 1'b0, 1'b0);
      HK_F7:  o_entry = mk(8'h83, 1'b0, 1'b0); HK_F8:  o_entry = mk(8'h0A, 1'b0, 1'b0);
      HK_F9:  o_entry = mk(8'h01, 1'b0, 1'b0); HK_F10: o_entry = mk(8'h09, 1'b0, 1'b0);
      HK_F11: o_entry = mk(8'h78, 1'b0, 1'b0); HK_F12: o_entry = mk(8'h07, 1'b0, 1'b0);
      default: o_entry = '0;
    endcase
  end
endmodule

// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder: character code to PS/2 Set-2 make/break byte stream.
// Define PS2_KEY_GAP_EN to insert GAP_CYCLES idle clocks after every byte.
module ps2_key_encoder
  import ps2_key_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  ps2_key_encoder_if.slave  bus
);
`ifdef PS2_KEY_GAP_EN
  parameter int GAP_CYCLES = 16;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  logic [GW-1:0] r_gap;
`endif
  state_t     r_state;
  lut_entry_t w_lut, r_entry;
  logic [2:0] r_idx;
  logic [7:0] r_scan_code;
  logic       r_scan_valid, r_char_ready, r_busy, r_unmapped;
  logic       w_accept, w_fire;
  ps2_key_lut u_lut (.i_char(bus.char_in), .o_entry(w_lut));
  assign w_accept = bus.char_valid & r_char_ready;
  assign w_fire   = r_scan_valid & bus.scan_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_entry      <= '0;
      r_idx        <= '0;
      r_scan_code  <= '0;
      r_scan_valid <= 1'b0;
      r_char_ready <= 1'b1;
      r_busy       <= 1'b0;
      r_unmapped   <= 1'b0;
`ifdef PS2_KEY_GAP_EN
      r_gap        <= '0;
`endif
    end else begin
      r_unmapped <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_unmapped <= ~w_lut.valid;
          if (w_lut.valid) begin
            r_state      <= SEND;
            r_entry      <= w_lut;
            r_idx        <= '0;
            r_scan_code  <= seq_byte(w_lut, 3'd0);
            r_scan_valid <= 1'b1;
            r_char_ready <= 1'b0;
            r_busy       <= 1'b1;
          end
        end
`ifdef PS2_KEY_GAP_EN
        SEND: if (w_fire) begin
          r_state      <= GAP;
          r_scan_valid <= 1'b0;
          r_gap        <= '0;
          r_idx        <= r_idx + 3'd1;
        end
        // r_idx already points past the byte just sent; reaching seq_len means done
        GAP: if (r_gap == GW'(GAP_CYCLES - 1)) begin
          if (r_idx == seq_len(r_entry)) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_char_ready <= 1'b1;
            r_busy       <= 1'b0;
          end else begin
            r_state      <= SEND;
            r_scan_code  <= seq_byte(r_entry, r_idx);
            r_scan_valid <= 1'b1;
          end
        end else r_gap <= r_gap + 1'b1;
`else
        SEND: if (w_fire) begin
          if (r_idx == seq_len(r_entry) - 3'd1) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_scan_valid <= 1'b0;
            r_char_ready <= 1'b1;
            r_busy       <= 1'b0;
          end else begin
            r_idx       <= r_idx + 3'd1;
            r_scan_code <= seq_byte(r_entry, r_idx + 3'd1);
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.char_ready = r_char_ready;
  assign bus.scan_code  = r_scan_code;
  assign bus.scan_valid = r_scan_valid;
  assign bus.busy       = r_busy;
  assign bus.unmapped   = r_unmapped;
endmodule

// File: tb/tb_ps2_key_encoder.sv
// tb_ps2_key_encoder: directed checks of ps2_key_encoder byte sequences, backpressure and reset
module tb_ps2_key_encoder;
  logic clk, rst_n;
  int total = 0;
  int bad = 0;
  ps2_key_encoder_if bus ();
  ps2_key_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " idle valid"}, 8'(bus.scan_valid), 8'd0);
    check({tag, " idle ready"}, 8'(bus.char_ready), 8'd1);
    check({tag, " idle busy"}, 8'(bus.busy), 8'd0);
  endtask

  task automatic run_seq(input string tag, input logic [7:0] c, input logic [47:0] exp, input int n);
    bus.char_in = c;
    bus.char_valid = 1'b1;
    tick();
    bus.char_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s b%0d valid", tag, i), 8'(bus.scan_valid), 8'd1);
      check($sformatf("%s b%0d code", tag, i), bus.scan_code, exp[47-8*i -: 8]);
      check($sformatf("%s b%0d busy", tag, i), 8'(bus.busy), 8'd1);
      check($sformatf("%s b%0d ready", tag, i), 8'(bus.char_ready), 8'd0);
      tick();
    end
    check_idle(tag);
  endtask

  logic [7:0] um [4];

  initial begin
    um = '{8'h7F, 8'd153, 8'd0, 8'd255};
    bus.char_in = 8'd0;
    bus.char_valid = 1'b0;
    bus.scan_ready = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    tick();
    check("rst scan_code", bus.scan_code, 8'h00);
    check("rst unmapped", 8'(bus.unmapped), 8'd0);
    check_idle("rst");
    rst_n = 1'b1;
    tick();
    check_idle("post rst");

    run_seq("a", 8'd97, 48'h1CF01C000000, 3);
    run_seq("A", 8'd65, 48'h121CF01CF012, 6);
    run_seq("up", 8'd131, 48'hE075E0F07500, 5);
    run_seq("?", 8'd63, 48'h124AF04AF012, 6);
    run_seq("tab", 8'd9, 48'h0DF00D000000, 3);
    run_seq("F12", 8'd152, 48'h07F007000000, 3);
    run_seq("F7", 8'd147, 48'h83F083000000, 3);
    run_seq("del", 8'd139, 48'hE071E0F07100, 5);
    run_seq("enter", 8'd128, 48'h5AF05A000000, 3);

    // char_valid held through the sequence: ignored while busy, re-accepted when ready returns
    bus.char_in = 8'd97;
    bus.char_valid = 1'b1;
    tick();
    check("hold b0", bus.scan_code, 8'h1C);
    tick();
    check("hold b1", bus.scan_code, 8'hF0);
    tick();
    check("hold b2", bus.scan_code, 8'h1C);
    tick();
    check_idle("hold");
    tick();
    bus.char_valid = 1'b0;
    check("hold again valid", 8'(bus.scan_valid), 8'd1);
    check("hold again b0", bus.scan_code, 8'h1C);
    tick();
    check("hold again b1", bus.scan_code, 8'hF0);
    tick();
    check("hold again b2", bus.scan_code, 8'h1C);
    tick();
    check_idle("hold again");

    // backpressure on byte 2 of '0'
    bus.char_in = 8'h30;
    bus.char_valid = 1'b1;
    tick();
    bus.char_valid = 1'b0;
    check("bp b0", bus.scan_code, 8'h45);
    tick();
    check("bp b1", bus.scan_code, 8'hF0);
    bus.scan_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp stall%0d code", i), bus.scan_code, 8'hF0);
      check($sformatf("bp stall%0d valid", i), 8'(bus.scan_valid), 8'd1);
    end
    bus.scan_ready = 1'b1;
    tick();
    check("bp b2", bus.scan_code, 8'h45);
    check("bp b2 valid", 8'(bus.scan_valid), 8'd1);
    tick();
    check_idle("bp");

    // unmapped codes pulse unmapped for one cycle and never start a sequence
    for (int k = 0; k < 4; k++) begin
      bus.char_in = um[k];
      bus.char_valid = 1'b1;
      tick();
      bus.char_valid = 1'b0;
      check($sformatf("um %h pulse", um[k]), 8'(bus.unmapped), 8'd1);
      check_idle("um");
      tick();
      check($sformatf("um %h clear", um[k]), 8'(bus.unmapped), 8'd0);
      check($sformatf("um %h novalid", um[k]), 8'(bus.scan_valid), 8'd0);
    end

    // asynchronous reset during byte 3 of 'A'
    bus.char_in = 8'd65;
    bus.char_valid = 1'b1;
    tick();
    bus.char_valid = 1'b0;
    tick();
    tick();
    check("mid b2", bus.scan_code, 8'hF0);
    #1 rst_n = 1'b0;
    #1;
    check("mid rst code", bus.scan_code, 8'h00);
    check_idle("mid rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check_idle("mid after");
    run_seq("recover", 8'd97, 48'h1CF01C000000, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
